// File: rtl/gru_pkg.sv
// Shared definitions for the GRU weight/bias fetch controller.
// Holds RAM geometry, the weight/bias row map, the RAM word type and the
// controller state encoding. No ports.
package gru_pkg;

  localparam int unsigned DWL    = 144;
  localparam int unsigned AWL    = 10;

  localparam int unsigned W_BASE = 0;
  localparam int unsigned W_ROWS = 585;
  localparam int unsigned B_BASE = 585;
  localparam int unsigned B_ROWS = 52;

  typedef logic [DWL-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/gru_rd_stream.sv
// Single-port read streamer: issues Rows reads starting at Base, tracks the one
// read in flight across the 1-cycle RAM latency, and buffers returned words in a
// 2-entry FIFO that feeds a valid/ready channel.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                reads may be issued this cycle
//   flush_i                 drop FIFO contents, in-flight read and row counter
//   clear_i                 rewind the row counter at end of frame
//   ram_en_o, ram_addr_o    RAM read request
//   ram_dout_i              RAM read data (one cycle after the request)
//   data_o, valid_o,        output stream; last_o marks row Rows-1
//   ready_i, last_o
//   issued_all_o            every row of the frame has been requested
//   idle_o                  FIFO empty and nothing in flight
module gru_rd_stream
  import gru_pkg::*;
#(
  parameter int unsigned Base = 0,
  parameter int unsigned Rows = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic           flush_i,
  input  logic           clear_i,
  output logic           ram_en_o,
  output logic [AWL-1:0] ram_addr_o,
  input  logic [DWL-1:0] ram_dout_i,
  output logic [DWL-1:0] data_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           last_o,
  output logic           issued_all_o,
  output logic           idle_o
);

  localparam int unsigned CntW = $clog2(Rows + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  word_t           mem_q [2];
  logic [1:0]      last_q;

  logic pop, push, issue;

  assign valid_o      = (fcnt_q != 2'd0);
  assign data_o       = mem_q[rd_ptr_q];
  assign last_o       = valid_o & last_q[rd_ptr_q];
  assign issued_all_o = (cnt_q == CntW'(Rows));
  assign idle_o       = (fcnt_q == 2'd0) & ~inflight_q;
  assign ram_en_o     = issue;
  assign ram_addr_o   = issue ? (AWL'(Base) + AWL'(cnt_q)) : '0;

  always_comb begin
    pop  = valid_o & ready_i;
    // Data returning the cycle of a flush belongs to the aborted frame.
    push = inflight_q & ~flush_i;
    // Only issue if the returning word is guaranteed a free FIFO slot.
    issue = enable_i & ~flush_i & (cnt_q < CntW'(Rows)) &
            (({1'b0, fcnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    cnt_d = cnt_q;
    if (flush_i || clear_i) begin
      cnt_d = '0;
    end else if (issue) begin
      cnt_d = cnt_q + CntW'(1);
    end

    inflight_d      = issue;
    inflight_last_d = issue & (cnt_q == CntW'(Rows - 1));

    if (flush_i) begin
      fcnt_d   = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      fcnt_d   = fcnt_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fcnt_q          <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      last_q          <= 2'b00;
    end else begin
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fcnt_q          <= fcnt_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      if (push) begin
        mem_q[wr_ptr_q]  <= ram_dout_i;
        last_q[wr_ptr_q] <= inflight_last_q;
      end
    end
  end

endmodule

// File: rtl/gru_wfetch_ctrl.sv
// GRU weight/bias fetch controller. On start, streams all weight rows through
// RAM port A and all bias rows through RAM port B, each on its own valid/ready
// channel, then pulses done. abort flushes the frame without done.
// Optional feature macro: GRU_WLOAD_EN adds a host load channel (ld_*) that
// writes RAM port A while idle; without it both RAM ports are read-only.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   start_i, abort_i               frame control pulses
//   busy_o, done_o                 frame status
//   w_data_o/w_valid_o/w_ready_i/w_last_o   weight stream
//   b_data_o/b_valid_o/b_ready_i/b_last_o   bias stream
//   ram_*_a_o, ram_dout_a_i        RAM port A (weights, host load)
//   ram_*_b_o, ram_dout_b_i        RAM port B (biases)
//   ld_valid_i/ld_ready_o/ld_addr_i/ld_data_i  host load (GRU_WLOAD_EN only)
module gru_wfetch_ctrl
  import gru_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
`ifdef GRU_WLOAD_EN
  input  logic           ld_valid_i,
  output logic           ld_ready_o,
  input  logic [AWL-1:0] ld_addr_i,
  input  logic [DWL-1:0] ld_data_i,
`endif
  output logic           busy_o,
  output logic           done_o,
  output logic [DWL-1:0] w_data_o,
  output logic           w_valid_o,
  input  logic           w_ready_i,
  output logic           w_last_o,
  output logic [DWL-1:0] b_data_o,
  output logic           b_valid_o,
  input  logic           b_ready_i,
  output logic           b_last_o,
  output logic           ram_en_a_o,
  output logic           ram_we_a_o,
  output logic [AWL-1:0] ram_addr_a_o,
  output logic [DWL-1:0] ram_din_a_o,
  input  logic [DWL-1:0] ram_dout_a_i,
  output logic           ram_en_b_o,
  output logic           ram_we_b_o,
  output logic [AWL-1:0] ram_addr_b_o,
  output logic [DWL-1:0] ram_din_b_o,
  input  logic [DWL-1:0] ram_dout_b_i
);

  state_e state_q, state_d;

  logic           go_run;
  logic           stream_en;
  logic           flush;
  logic           a_ram_en, b_ram_en;
  logic [AWL-1:0] a_ram_addr;
  logic           a_all, b_all, a_idle, b_idle;

  assign busy_o    = (state_q != StIdle);
  assign flush     = abort_i & (state_q != StIdle);
  // Streams start issuing in the start cycle itself so the first row is valid
  // two clocks after start.
  assign stream_en = go_run | ((state_q == StRun) & ~abort_i);

`ifdef GRU_WLOAD_EN
  logic start_pend_q, start_pend_d;
  logic ld_acc, start_req;

  assign ld_ready_o   = (state_q == StIdle);
  assign ld_acc       = ld_valid_i & ld_ready_o;
  assign start_req    = (start_i | start_pend_q) & (state_q == StIdle);
  // A load beat owns port A this cycle; the start waits for a free cycle.
  assign go_run       = start_req & ~ld_acc;
  assign start_pend_d = start_req & ld_acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_pend_q <= 1'b0;
    end else begin
      start_pend_q <= start_pend_d;
    end
  end

  assign ram_en_a_o   = ld_acc | a_ram_en;
  assign ram_we_a_o   = ld_acc;
  assign ram_addr_a_o = ld_acc ? ld_addr_i : a_ram_addr;
  assign ram_din_a_o  = ld_acc ? ld_data_i : '0;
`else
  assign go_run       = start_i & (state_q == StIdle);
  assign ram_en_a_o   = a_ram_en;
  assign ram_we_a_o   = 1'b0;
  assign ram_addr_a_o = a_ram_addr;
  assign ram_din_a_o  = '0;
`endif

  assign ram_en_b_o  = b_ram_en;
  assign ram_we_b_o  = 1'b0;
  assign ram_din_b_o = '0;

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_run) state_d = StRun;
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (a_all && b_all) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (a_idle && b_idle) begin
          state_d = StIdle;
          done_o  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  gru_rd_stream #(
    .Base(W_BASE),
    .Rows(W_ROWS)
  ) u_w_stream (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (stream_en),
    .flush_i     (flush),
    .clear_i     (done_o),
    .ram_en_o    (a_ram_en),
    .ram_addr_o  (a_ram_addr),
    .ram_dout_i  (ram_dout_a_i),
    .data_o      (w_data_o),
    .valid_o     (w_valid_o),
    .ready_i     (w_ready_i),
    .last_o      (w_last_o),
    .issued_all_o(a_all),
    .idle_o      (a_idle)
  );

  gru_rd_stream #(
    .Base(B_BASE),
    .Rows(B_ROWS)
  ) u_b_stream (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (stream_en),
    .flush_i     (flush),
    .clear_i     (done_o),
    .ram_en_o    (b_ram_en),
    .ram_addr_o  (ram_addr_b_o),
    .ram_dout_i  (ram_dout_b_i),
    .data_o      (b_data_o),
    .valid_o     (b_valid_o),
    .ready_i     (b_ready_i),
    .last_o      (b_last_o),
    .issued_all_o(b_all),
    .idle_o      (b_idle)
  );

endmodule

// File: tb/tb_gru_wfetch_ctrl.sv
// Self-checking bench for gru_wfetch_ctrl: behavioural 1-cycle RAM preloaded
// with mem[i] = i, scoreboard queues of expected weight/bias beats.
module tb_gru_wfetch_ctrl;
  import gru_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, abort;
  logic           busy, done;
  logic [DWL-1:0] w_data, b_data;
  logic           w_valid, w_ready, w_last;
  logic           b_valid, b_ready, b_last;
  logic           ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AWL-1:0] ram_addr_a, ram_addr_b;
  logic [DWL-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
`ifdef GRU_WLOAD_EN
  logic           ld_valid, ld_ready;
  logic [AWL-1:0] ld_addr;
  logic [DWL-1:0] ld_data;
`endif

  gru_wfetch_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
`ifdef GRU_WLOAD_EN
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .w_data_o    (w_data),
    .w_valid_o   (w_valid),
    .w_ready_i   (w_ready),
    .w_last_o    (w_last),
    .b_data_o    (b_data),
    .b_valid_o   (b_valid),
    .b_ready_i   (b_ready),
    .b_last_o    (b_last),
    .ram_en_a_o  (ram_en_a),
    .ram_we_a_o  (ram_we_a),
    .ram_addr_a_o(ram_addr_a),
    .ram_din_a_o (ram_din_a),
    .ram_dout_a_i(ram_dout_a),
    .ram_en_b_o  (ram_en_b),
    .ram_we_b_o  (ram_we_b),
    .ram_addr_b_o(ram_addr_b),
    .ram_din_b_o (ram_din_b),
    .ram_dout_b_i(ram_dout_b)
  );

  // Behavioural dual-port RAM, read-first, 1-cycle registered read.
  logic           mem_init;
  logic [DWL-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= DWL'(i);
    end else begin
      if (ram_en_a) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_a <= mem[ram_addr_a];
      end
      if (ram_en_b) begin
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        ram_dout_b <= mem[ram_addr_b];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {last, data}
  logic [DWL:0] wq[$];
  logic [DWL:0] bq[$];

  int w_beats, b_beats, done_cnt;
  int start_cyc, first_w_cyc, first_b_cyc, last_w_cyc, last_b_cyc, done_cyc;
  bit w_seen, b_seen;
  int w_mode = 0;  // 0: ready high, 1: random
  int b_mode = 0;  // 0: ready high, 1: random, 2: stall after 3 beats

  // Ready drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    w_ready = (w_mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
    case (b_mode)
      0:       b_ready = 1'b1;
      1:       b_ready = 1'(($urandom_range(0, 1)));
      default: b_ready = (b_beats < 3);
    endcase
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  bit           w_hold, b_hold;
  logic [DWL:0] w_hold_val, b_hold_val;
  logic [DWL:0] exp_beat;
  always @(negedge clk) begin
    if (rst || mem_init) begin
      w_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (w_hold) check_eq("w_hold", {w_valid, w_last, w_data}, {1'b1, w_hold_val});
      if (b_hold) check_eq("b_hold", {b_valid, b_last, b_data}, {1'b1, b_hold_val});
      if (w_valid && !w_seen) begin
        w_seen = 1'b1;
        first_w_cyc = cyc;
      end
      if (b_valid && !b_seen) begin
        b_seen = 1'b1;
        first_b_cyc = cyc;
      end
      if (w_valid && w_ready) begin
        check_eq("w_sb_empty", wq.size() == 0, 0);
        if (wq.size() != 0) begin
          exp_beat = wq.pop_front();
          check_eq("w_beat", {w_last, w_data}, exp_beat);
        end
        w_beats++;
        if (w_last) last_w_cyc = cyc;
      end
      if (b_valid && b_ready) begin
        check_eq("b_sb_empty", bq.size() == 0, 0);
        if (bq.size() != 0) begin
          exp_beat = bq.pop_front();
          check_eq("b_beat", {b_last, b_data}, exp_beat);
        end
        b_beats++;
        if (b_last) last_b_cyc = cyc;
      end
      w_hold     = w_valid & ~w_ready & ~abort;
      w_hold_val = {w_last, w_data};
      b_hold     = b_valid & ~b_ready & ~abort;
      b_hold_val = {b_last, b_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_frame();
    word_t v;
    logic  l;
    for (int i = 0; i < int'(W_ROWS); i++) begin
      v = word_t'(W_BASE + i);
      l = (i == int'(W_ROWS) - 1);
      wq.push_back({l, v});
    end
    for (int i = 0; i < int'(B_ROWS); i++) begin
      v = word_t'(B_BASE + i);
      l = (i == int'(B_ROWS) - 1);
      bq.push_back({l, v});
    end
  endtask

  task automatic do_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    w_seen    = 1'b0;
    b_seen    = 1'b0;
    w_beats   = 0;
    b_beats   = 0;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int t = 0;
    while (done_cnt == base && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("done_seen", done_cnt != base, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_w_valid"}, w_valid, 0);
    check_eq({tag, "_b_valid"}, b_valid, 0);
    check_eq({tag, "_w_last"}, w_last, 0);
    check_eq({tag, "_b_last"}, b_last, 0);
    check_eq({tag, "_ram_en_a"}, ram_en_a, 0);
    check_eq({tag, "_ram_en_b"}, ram_en_b, 0);
    check_eq({tag, "_ram_we_a"}, ram_we_a, 0);
    check_eq({tag, "_ram_we_b"}, ram_we_b, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t;
  int base_done;

  initial begin
    rst      = 1'b1;
    mem_init = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
`ifdef GRU_WLOAD_EN
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    check_idle_outputs("rst");
    check_eq("rst_din_b", ram_din_b, 0);
    check_eq("rst_addr_a", ram_addr_a, 0);
    check_eq("rst_addr_b", ram_addr_b, 0);
    rst = 1'b0;

    // Full frame, ready held high
    do_start();
    check_eq("run_busy", busy, 1);
    check_eq("run_we_a", ram_we_a, 0);
    wait_done(3000);
    check_eq("full_w_lat", first_w_cyc - start_cyc, 2);
    check_eq("full_b_lat", first_b_cyc - start_cyc, 2);
    check_eq("full_w_beats", w_beats, W_ROWS);
    check_eq("full_b_beats", b_beats, B_ROWS);
    check_eq("full_w_rate", last_w_cyc - first_w_cyc, W_ROWS - 1);
    check_eq("full_b_rate", last_b_cyc - first_b_cyc, B_ROWS - 1);
    check_eq("full_done_cyc", done_cyc,
             ((last_w_cyc > last_b_cyc) ? last_w_cyc : last_b_cyc) + 1);
    check_eq("full_wq_left", wq.size(), 0);
    check_eq("full_bq_left", bq.size(), 0);
    check_eq("full_busy_after", busy, 0);

    // Random back-pressure on both streams
    w_mode = 1;
    b_mode = 1;
    do_start();
    wait_done(5000);
    w_mode = 0;
    b_mode = 0;
    check_eq("rand_w_beats", w_beats, W_ROWS);
    check_eq("rand_b_beats", b_beats, B_ROWS);
    check_eq("rand_wq_left", wq.size(), 0);
    check_eq("rand_bq_left", bq.size(), 0);

    // Bias stream stalls after 3 beats; weights must still complete
    b_mode = 2;
    base_done = done_cnt;
    do_start();
    t = 0;
    while (w_beats < int'(W_ROWS) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (20) @(posedge clk);
    #1;
    check_eq("stall_w_beats", w_beats, W_ROWS);
    check_eq("stall_b_beats", b_beats, 3);
    check_eq("stall_no_done", done_cnt, base_done);
    check_eq("stall_b_valid", b_valid, 1);
    check_eq("stall_busy", busy, 1);
    b_mode = 0;
    wait_done(1000);
    check_eq("stall_bq_left", bq.size(), 0);
    check_eq("stall_wq_left", wq.size(), 0);

    // Abort 10 clocks after start
    base_done = done_cnt;
    do_start();
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wq.delete();
    bq.delete();
    check_idle_outputs("abort");
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, base_done);
    check_eq("abort_w_valid_later", w_valid, 0);
    do_start();
    wait_done(3000);
    check_eq("replay_w_lat", first_w_cyc - start_cyc, 2);
    check_eq("replay_w_beats", w_beats, W_ROWS);
    check_eq("replay_wq_left", wq.size(), 0);
    check_eq("replay_bq_left", bq.size(), 0);

    // Reset mid-frame
    do_start();
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    bq.delete();
    check_idle_outputs("midrst");
    do_start();
    wait_done(3000);
    check_eq("postrst_w_beats", w_beats, W_ROWS);
    check_eq("postrst_b_beats", b_beats, B_ROWS);
    check_eq("postrst_wq_left", wq.size(), 0);

`ifdef GRU_WLOAD_EN
    // Host load of row 5 while idle, then a frame
    @(posedge clk);
    #1;
    check_eq("ld_ready_idle", ld_ready, 1);
    ld_valid = 1'b1;
    ld_addr  = AWL'(5);
    ld_data  = DWL'(12'hABC);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    do_start();
    wq[5] = {1'b0, DWL'(12'hABC)};
    repeat (5) @(posedge clk);
    #1;
    check_eq("ld_ready_busy", ld_ready, 0);
    wait_done(3000);
    check_eq("ld_wq_left", wq.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
